// File: rtl/planificador_solicitudes_if.sv
// Signal bundle between the elevator input/FSM side and the request scheduler.
interface planificador_solicitudes_if;
  logic       LE;
  logic [3:0] boton_pres;
  logic [1:0] piso;
  logic [1:0] accion;
  logic       puertas;
  logic [3:0] memoria;
  logic [9:0] pendientes;
  logic [1:0] direccion;

  modport master (
    output LE, boton_pres, piso, accion, puertas,
    input  memoria, pendientes, direccion
  );

  modport slave (
    input  LE, boton_pres, piso, accion, puertas,
    output memoria, pendientes, direccion
  );
endinterface

// File: rtl/planificador_solicitudes.sv
// SCAN request scheduler: latches button codes into a pending bitmap, clears served
// floors, and registers the next instruction code for the floor FSM when LE is high.
module planificador_solicitudes #(
  parameter int N_PISOS = 4,
  parameter int N_COD   = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  planificador_solicitudes_if.slave bus
);

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    SUBIENDO = 2'd1,
    BAJANDO  = 2'd2
  } dir_e;

  localparam logic [3:0] COD_MAX = 4'(N_COD);
  localparam logic [3:0] ALL_F   = 4'((1 << N_PISOS) - 1);

  // Pending-bitmap bits belonging to each floor (bit k-1 = code k).
  function automatic logic [9:0] floor_mask(input logic [1:0] f);
    case (f)
      2'd0:    floor_mask = 10'b00_0001_0001;
      2'd1:    floor_mask = 10'b00_0110_0010;
      2'd2:    floor_mask = 10'b01_1000_0100;
      2'd3:    floor_mask = 10'b10_0000_1000;
      default: floor_mask = 10'b00_0000_0000;
    endcase
  endfunction

  // Lowest-numbered pending code that maps to floor f.
  function automatic logic [3:0] first_code(input logic [1:0] f, input logic [9:0] p);
    case (f)
      2'd0:    first_code = p[0] ? 4'd1 : (p[4] ? 4'd5 : 4'd0);
      2'd1:    first_code = p[1] ? 4'd2 : (p[5] ? 4'd6 : (p[6] ? 4'd7 : 4'd0));
      2'd2:    first_code = p[2] ? 4'd3 : (p[7] ? 4'd8 : (p[8] ? 4'd9 : 4'd0));
      2'd3:    first_code = p[3] ? 4'd4 : (p[9] ? 4'd10 : 4'd0);
      default: first_code = 4'd0;
    endcase
  endfunction

  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    casez (v)
      4'b???1: lowest_idx = 2'd0;
      4'b??10: lowest_idx = 2'd1;
      4'b?100: lowest_idx = 2'd2;
      4'b1000: lowest_idx = 2'd3;
      default: lowest_idx = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] highest_idx(input logic [3:0] v);
    casez (v)
      4'b1???: highest_idx = 2'd3;
      4'b01??: highest_idx = 2'd2;
      4'b001?: highest_idx = 2'd1;
      4'b0001: highest_idx = 2'd0;
      default: highest_idx = 2'd0;
    endcase
  endfunction

  logic [9:0] pend_q, pend_d;
  dir_e       dir_q, dir_d;
  logic [3:0] mem_q, mem_d;

  logic [9:0] set_mask, clr_mask;
  logic [3:0] req, req_ge, req_le, req_above, req_below;
  logic [1:0] up_f, dn_f, dist_up, dist_dn, tgt;
  logic       tgt_valid;
  dir_e       dir_n;

  // Capture and clear of the pending bitmap; a served floor's clear beats a same-cycle set.
  always_comb begin
    set_mask = 10'b0;
    clr_mask = 10'b0;
    if ((bus.boton_pres >= 4'd1) && (bus.boton_pres <= COD_MAX)) begin
      set_mask = 10'b1 << (bus.boton_pres - 4'd1);
    end else begin
      set_mask = 10'b0;
    end
    if (bus.puertas && (bus.accion == 2'd0)) begin
      clr_mask = floor_mask(bus.piso);
    end else begin
      clr_mask = 10'b0;
    end
    pend_d = (pend_q | set_mask) & ~clr_mask;
  end

  // Per-floor request summary split relative to the current floor.
  always_comb begin
    req = 4'b0;
    for (int f = 0; f < 4; f++) begin
      req[f] = |(pend_q & floor_mask(2'(f)));
    end
    req       = req & ALL_F;
    req_ge    = req & (4'b1111 << bus.piso);
    req_above = req & (4'b1110 << bus.piso);
    req_le    = req & (4'b1111 >> (2'd3 - bus.piso));
    req_below = req & (4'b0111 >> (2'd3 - bus.piso));
    up_f      = lowest_idx(req_above);
    dn_f      = highest_idx(req_below);
    dist_up   = up_f - bus.piso;
    dist_dn   = bus.piso - dn_f;
  end

  // SCAN target selection: keep the travel direction while requests lie ahead.
  always_comb begin
    tgt_valid = 1'b0;
    tgt       = bus.piso;
    dir_n     = REPOSO;
    case (dir_q)
      REPOSO: begin
        if (req[bus.piso]) begin
          tgt_valid = 1'b1;
          tgt       = bus.piso;
          dir_n     = REPOSO;
        end else if ((|req_below) && (!(|req_above) || (dist_dn <= dist_up))) begin
          tgt_valid = 1'b1;
          tgt       = dn_f;
          dir_n     = BAJANDO;
        end else if (|req_above) begin
          tgt_valid = 1'b1;
          tgt       = up_f;
          dir_n     = SUBIENDO;
        end else begin
          tgt_valid = 1'b0;
          dir_n     = REPOSO;
        end
      end
      SUBIENDO: begin
        if (|req_ge) begin
          tgt_valid = 1'b1;
          tgt       = lowest_idx(req_ge);
          dir_n     = SUBIENDO;
        end else if (|req_below) begin
          tgt_valid = 1'b1;
          tgt       = dn_f;
          dir_n     = BAJANDO;
        end else begin
          tgt_valid = 1'b0;
          dir_n     = REPOSO;
        end
      end
      BAJANDO: begin
        if (|req_le) begin
          tgt_valid = 1'b1;
          tgt       = highest_idx(req_le);
          dir_n     = BAJANDO;
        end else if (|req_above) begin
          tgt_valid = 1'b1;
          tgt       = up_f;
          dir_n     = SUBIENDO;
        end else begin
          tgt_valid = 1'b0;
          dir_n     = REPOSO;
        end
      end
      default: begin
        tgt_valid = 1'b0;
        dir_n     = REPOSO;
      end
    endcase
  end

  // Output registers only move while the FSM is not sampling (LE high).
  always_comb begin
    if (bus.LE) begin
      mem_d = tgt_valid ? first_code(tgt, pend_q) : 4'd0;
      dir_d = dir_n;
    end else begin
      mem_d = mem_q;
      dir_d = dir_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 10'b0;
      dir_q  <= REPOSO;
      mem_q  <= 4'd0;
    end else begin
      pend_q <= pend_d;
      dir_q  <= dir_d;
      mem_q  <= mem_d;
    end
  end

  assign bus.memoria    = mem_q;
  assign bus.pendientes = pend_q;
  assign bus.direccion  = dir_q;

endmodule

// File: tb/tb_planificador_solicitudes.sv
// Directed bench for the SCAN request scheduler with hand-computed expectations.
module tb_planificador_solicitudes;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  planificador_solicitudes_if bus ();

  planificador_solicitudes dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.boton_pres = 4'd0;
    bus.puertas    = 1'b0;
    bus.accion     = 2'd0;
    bus.LE         = 1'b1;
    bus.piso       = 2'd0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.boton_pres = 4'd3;
    bus.LE         = 1'b1;
    rst            = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (bus.pendientes !== 10'b0) begin
        $display("FAIL reset_pend got=%b exp=%b", bus.pendientes, 10'b0); bad++;
      end
      total++;
      if (bus.memoria !== 4'd0) begin
        $display("FAIL reset_mem got=%0d exp=0", bus.memoria); bad++;
      end
      total++;
      if (bus.direccion !== 2'd0) begin
        $display("FAIL reset_dir got=%0d exp=0", bus.direccion); bad++;
      end
    end
    rst = 1'b0;
    step();
    total++;
    if (bus.pendientes !== 10'b0000000100) begin
      $display("FAIL reset_release_pend got=%b exp=%b", bus.pendientes, 10'b0000000100); bad++;
    end
    bus.boton_pres = 4'd0;
  endtask

  task automatic test_simple_call();
    do_reset();
    bus.piso       = 2'd0;
    bus.boton_pres = 4'd4;
    step();
    bus.boton_pres = 4'd0;
    total++;
    if (bus.pendientes !== 10'b0000001000) begin
      $display("FAIL call_pend got=%b exp=%b", bus.pendientes, 10'b0000001000); bad++;
    end
    step();
    total++;
    if (bus.memoria !== 4'd4 || bus.direccion !== 2'd1) begin
      $display("FAIL call_target got=%0d/%0d exp=4/1", bus.memoria, bus.direccion); bad++;
    end
    bus.piso    = 2'd3;
    bus.puertas = 1'b1;
    bus.accion  = 2'd0;
    step();
    bus.puertas = 1'b0;
    total++;
    if (bus.pendientes !== 10'b0 || bus.memoria !== 4'd4) begin
      $display("FAIL call_clear got=%b/%0d exp=%b/4", bus.pendientes, bus.memoria, 10'b0); bad++;
    end
    step();
    total++;
    if (bus.memoria !== 4'd0 || bus.direccion !== 2'd0) begin
      $display("FAIL call_idle got=%0d/%0d exp=0/0", bus.memoria, bus.direccion); bad++;
    end
  endtask

  task automatic test_scan_order();
    do_reset();
    bus.piso       = 2'd1;
    bus.boton_pres = 4'd9;
    step();
    bus.boton_pres = 4'd1;
    step();
    bus.boton_pres = 4'd0;
    step();
    total++;
    if (bus.memoria !== 4'd9 || bus.direccion !== 2'd1) begin
      $display("FAIL scan_up got=%0d/%0d exp=9/1", bus.memoria, bus.direccion); bad++;
    end
    bus.piso    = 2'd2;
    bus.puertas = 1'b1;
    bus.accion  = 2'd1;
    step();
    total++;
    if (bus.pendientes !== 10'b0100000001) begin
      $display("FAIL scan_moving_noclear got=%b exp=%b", bus.pendientes, 10'b0100000001); bad++;
    end
    bus.accion = 2'd0;
    step();
    bus.puertas = 1'b0;
    total++;
    if (bus.pendientes !== 10'b0000000001 || bus.memoria !== 4'd9) begin
      $display("FAIL scan_clear got=%b/%0d exp=%b/9", bus.pendientes, bus.memoria, 10'b0000000001); bad++;
    end
    step();
    total++;
    if (bus.memoria !== 4'd1 || bus.direccion !== 2'd2) begin
      $display("FAIL scan_reverse got=%0d/%0d exp=1/2", bus.memoria, bus.direccion); bad++;
    end
  endtask

  task automatic test_le_hold();
    do_reset();
    bus.piso       = 2'd2;
    bus.boton_pres = 4'd3;
    step();
    bus.boton_pres = 4'd0;
    step();
    total++;
    if (bus.memoria !== 4'd3 || bus.direccion !== 2'd0) begin
      $display("FAIL hold_setup got=%0d/%0d exp=3/0", bus.memoria, bus.direccion); bad++;
    end
    bus.LE         = 1'b0;
    bus.boton_pres = 4'd2;
    step();
    bus.boton_pres = 4'd0;
    total++;
    if (bus.pendientes !== 10'b0000000110 || bus.memoria !== 4'd3) begin
      $display("FAIL hold_press got=%b/%0d exp=%b/3", bus.pendientes, bus.memoria, 10'b0000000110); bad++;
    end
    step();
    bus.puertas = 1'b1;
    step();
    bus.puertas = 1'b0;
    total++;
    if (bus.pendientes !== 10'b0000000010 || bus.memoria !== 4'd3) begin
      $display("FAIL hold_clear got=%b/%0d exp=%b/3", bus.pendientes, bus.memoria, 10'b0000000010); bad++;
    end
    step();
    step();
    total++;
    if (bus.memoria !== 4'd3 || bus.direccion !== 2'd0) begin
      $display("FAIL hold_end got=%0d/%0d exp=3/0", bus.memoria, bus.direccion); bad++;
    end
    bus.LE = 1'b1;
    step();
    total++;
    if (bus.memoria !== 4'd2 || bus.direccion !== 2'd2) begin
      $display("FAIL hold_resume got=%0d/%0d exp=2/2", bus.memoria, bus.direccion); bad++;
    end
  endtask

  task automatic test_collision();
    do_reset();
    bus.piso       = 2'd2;
    bus.puertas    = 1'b1;
    bus.accion     = 2'd0;
    bus.boton_pres = 4'd8;
    step();
    total++;
    if (bus.pendientes !== 10'b0) begin
      $display("FAIL collide_same got=%b exp=%b", bus.pendientes, 10'b0); bad++;
    end
    bus.boton_pres = 4'd10;
    step();
    total++;
    if (bus.pendientes !== 10'b1000000000) begin
      $display("FAIL collide_other got=%b exp=%b", bus.pendientes, 10'b1000000000); bad++;
    end
    bus.boton_pres = 4'd0;
    bus.puertas    = 1'b0;
  endtask

  task automatic test_tie_illegal();
    do_reset();
    bus.piso       = 2'd1;
    bus.LE         = 1'b0;
    bus.boton_pres = 4'd5;
    step();
    bus.boton_pres = 4'd3;
    step();
    total++;
    if (bus.pendientes !== 10'b0000010100) begin
      $display("FAIL tie_pend got=%b exp=%b", bus.pendientes, 10'b0000010100); bad++;
    end
    bus.LE         = 1'b1;
    bus.boton_pres = 4'd12;
    step();
    total++;
    if (bus.pendientes !== 10'b0000010100) begin
      $display("FAIL illegal12 got=%b exp=%b", bus.pendientes, 10'b0000010100); bad++;
    end
    total++;
    if (bus.memoria !== 4'd5 || bus.direccion !== 2'd2) begin
      $display("FAIL tie_lower got=%0d/%0d exp=5/2", bus.memoria, bus.direccion); bad++;
    end
    bus.boton_pres = 4'd15;
    step();
    bus.boton_pres = 4'd0;
    total++;
    if (bus.pendientes !== 10'b0000010100) begin
      $display("FAIL illegal15 got=%b exp=%b", bus.pendientes, 10'b0000010100); bad++;
    end
  endtask

  task automatic test_all_codes();
    do_reset();
    bus.piso = 2'd0;
    bus.LE   = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      bus.boton_pres = 4'(c);
      step();
    end
    bus.boton_pres = 4'd4;
    step();
    bus.boton_pres = 4'd0;
    total++;
    if (bus.pendientes !== 10'h3FF) begin
      $display("FAIL all_pend got=%b exp=%b", bus.pendientes, 10'h3FF); bad++;
    end
    bus.LE = 1'b1;
    step();
    total++;
    if (bus.memoria !== 4'd1 || bus.direccion !== 2'd0) begin
      $display("FAIL all_here got=%0d/%0d exp=1/0", bus.memoria, bus.direccion); bad++;
    end
    bus.puertas = 1'b1;
    step();
    bus.puertas = 1'b0;
    total++;
    if (bus.pendientes !== 10'h3EE) begin
      $display("FAIL all_clear_f0 got=%b exp=%b", bus.pendientes, 10'h3EE); bad++;
    end
    step();
    total++;
    if (bus.memoria !== 4'd2 || bus.direccion !== 2'd1) begin
      $display("FAIL all_next got=%0d/%0d exp=2/1", bus.memoria, bus.direccion); bad++;
    end
  endtask

  initial begin
    clk            = 1'b0;
    rst            = 1'b1;
    total          = 0;
    bad            = 0;
    bus.LE         = 1'b1;
    bus.boton_pres = 4'd0;
    bus.piso       = 2'd0;
    bus.accion     = 2'd0;
    bus.puertas    = 1'b0;
    test_reset();
    test_simple_call();
    test_scan_order();
    test_le_hold();
    test_collision();
    test_tie_illegal();
    test_all_codes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/planificador_solicitudes.md
Name: planificador_solicitudes

Overview:
- Request scheduler that produces the 4-bit instruction code consumed by the elevator floor FSM.
- Latches decoded button codes from the input-handling block into a pending-request bitmap.
- Clears requests when the cabin reports doors open at a floor.
- Selects the next code with a SCAN (keep-direction) policy, so the FSM receives a stable target and cannot oscillate between floors.

Parameters:
- N_PISOS, 4, number of floors; fixed at 4 in this revision and used only for range checks.
- N_COD, 10, number of valid request codes (1..10).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- LE  input  1  load enable; 1 = memoria/direction may update, 0 = FSM is sampling, so memoria and direction hold
- boton_pres  input  4  decoded button code this cycle (0 none, 1..4 cabin floor 1..4, 5 P1 up, 6 P2 down, 7 P2 up, 8 P3 down, 9 P3 up, 10 P4 down)
- piso  input  2  current floor (0..3)
- accion  input  2  0 idle, 1 rising, 2 falling
- puertas  input  1  1 = doors open
- memoria  output  4  next instruction code for the FSM (0 = nothing pending)
- pendientes  output  10  pending bitmap; bit k-1 = code k
- direccion  output  2  scheduler state: 0 REPOSO, 1 SUBIENDO, 2 BAJANDO

Behaviour:
- Clock and reset:
  - Single clock, all state on posedge clk.
  - rst is synchronous and active-high. It clears pendientes=0, direccion=REPOSO, memoria=0 and overrides every other input the same cycle.
  - Reset mid-travel drops all requests.
- Floor-to-code map:
  - F0 = {1,5}
  - F1 = {2,6,7}
  - F2 = {3,8,9}
  - F3 = {4,10}
  - req_f[f] = OR of the pending bits of floor f's codes.
- Capture:
  - If boton_pres is in 1..10, set the pending bit next cycle; this is independent of LE.
  - Codes 0 and 11..15 are ignored.
  - A repeated press is idempotent.
- Clear:
  - When puertas==1 and accion==0, clear every bit of floor piso next cycle.
  - Set and clear of the same bit in the same cycle: clear wins, because the request is considered served.
  - A press for a different floor in that cycle is still captured.
- Selection and output:
  - Evaluated from the registered pendientes and current piso, and registered into memoria/direccion only when LE==1.
  - REPOSO:
    - If req_f[piso], target = piso, direccion stays REPOSO.
    - Else target = nearest pending floor; on a distance tie, take the lower floor.
    - direccion becomes SUBIENDO or BAJANDO according to where the target lies.
    - With no request, memoria=0.
  - SUBIENDO:
    - If any req_f[f] with f >= piso, target = lowest such f.
    - Else if any below, direccion=BAJANDO and target = highest f < piso.
    - Else direccion=REPOSO and memoria=0.
  - BAJANDO: mirror of SUBIENDO. Target = highest f <= piso, else reverse, else REPOSO.
  - memoria = lowest-numbered pending code mapping to the target floor; for example, F1 with 6 and 7 pending outputs 6.
- Latency:
  - Press at cycle n: pendientes visible at n+1, memoria valid at n+2 if LE==1 at n+1.
  - While LE==0, memoria holds its value; the next LE==1 cycle updates memoria from current state.
- Boundaries:
  - All 10 codes pending is legal.
  - piso outside a requested range needs no special case; the 2-bit value covers 0..3.
  - The doors-open clear while LE==0 still clears pendientes; memoria updates at the next LE==1.

Test Plan:
- Reset: rst=1 for 2 cycles while boton_pres=3 -> pendientes=0, memoria=0, direccion=0 throughout; after release the press at cycle n gives pendientes=10'b0000000100 at n+1.
- Simple call: piso=0, LE=1, press code 4 at cycle n -> memoria=4, direccion=1 at n+2; then piso=3, puertas=1, accion=0 -> bit3 cleared next cycle, memoria=0, direccion=0 the cycle after.
- SCAN order: piso=1, direccion=SUBIENDO, pending codes 1 and 9 -> memoria=9 (F2). After F2 clears with piso=2 -> memoria=1, direccion=2.
- LE hold: memoria=3 with LE=0 for 5 cycles while code 2 is pressed -> memoria stays 3; pendientes shows bit1 set the cycle after the press; memoria is re-evaluated on the first LE=1 cycle.
- Set/clear collision: piso=2, puertas=1, accion=0, press code 8 the same cycle -> bit7 remains 0. Press code 10 the same cycle -> bit9 set.
- Tie in REPOSO: piso=1, pending codes 5 (F0) and 3 (F2) -> memoria=5, direccion=2; illegal code 12 pressed -> pendientes unchanged.
